sbox_sequencer: RTL and testbench
=================================

# sbox_sequencer

Time-multiplexes one shared DES S-box lookup port across the eight S-box substitutions of a Feistel round. It accepts a 48-bit post-key-XOR word, presents its eight 6-bit chunks to the external S-box bank one per cycle, and assembles the eight 4-bit results into the 32-bit substitution output ahead of the P-permutation. It sits between the round's E-expansion/key-XOR stage and the P-box, and replaces eight parallel S-box instances with one lookup port.

## Interface
- No parameters. Chunk count (8), chunk width (6) and result width (4) are fixed by DES.
- clk  input  1  system clock; all state updates on the rising edge
- n_rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_48bit is valid
- in_ready  output  1  block can accept a word
- in_48bit  input  48  E-expanded data XOR round subkey
- sbox_sel  output  3  S-box select: 0 = S1 … 7 = S8
- sbox_in  output  6  6-bit input to the selected S-box
- sbox_out  input  4  combinational S-box result for sbox_sel/sbox_in
- out_valid  output  1  out_32bit holds a complete result
- out_ready  input  1  downstream accepts out_32bit
- out_32bit  output  32  assembled substitution result
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, LOOKUP, DONE.
- IDLE: in_ready=1. If in_valid=1 at the edge, latch in_48bit, clear index k to 0, clear the result register, and go to LOOKUP.
- LOOKUP: sbox_sel=k, sbox_in=data[47-6k -: 6], so S1 takes bits 47:42. At each edge, write sbox_out into result[31-4k -: 4]. If k==7, go to DONE; otherwise increment k.
- DONE: out_valid=1 and out_32bit=result. If out_ready=1 at the edge, go to IDLE.
- in_ready is 1 only in IDLE. in_valid is ignored in LOOKUP and DONE, and the input is not captured.
- out_32bit is held stable throughout DONE. Outside DONE it shows the result register; its value there is don't-care to the consumer.
- sbox_sel and sbox_in are driven from registered state only, with no combinational path from any input. Outside LOOKUP they are 0.
- k is 3 bits wide. It never wraps in normal flow because it exits at 7.
- Reset, including mid-LOOKUP or mid-DONE: state=IDLE, k=0, data=0, result=0. Outputs after reset: in_ready=1, out_valid=0, busy=0, sbox_sel=0, sbox_in=0, out_32bit=0. A partial result is discarded and is never presented.

## Timing
- The input is accepted at edge E0.
- LOOKUP occupies the 8 cycles following E0. Chunk k is presented in cycle k+1 and captured at edge E(k+1).
- out_valid rises after E8 and stays high until the first edge with out_ready=1.
- Minimum occupancy is 10 cycles per word: 1 IDLE + 8 LOOKUP + 1 DONE with out_ready already high.
- The external S-box must settle sbox_out within the same cycle that sbox_sel/sbox_in are presented.
- Back-to-back words: the next word is accepted no earlier than the IDLE cycle that follows the DONE handshake.

## Configuration
- SBOX_SEQ_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in LOOKUP or DONE forces IDLE and clears k and result. out_valid=0 from the next cycle.
  - In IDLE, abort has priority over in_valid: the word is not accepted.
- SBOX_SEQ_ABORT_EN undefined:
  - The abort port does not exist.
  - Only n_rst terminates an operation.

## Test plan
- Reset, then in_48bit=48'h000000000000 with the standard S1–S8 model. Required: sbox_in=0 for sel 0..7 on cycles 1..8, out_valid on cycle 9, out_32bit=32'hEFA72C4D.
- in_48bit=48'hFFFFFFFFFFFF. Required: sbox_in=6'h3F every LOOKUP cycle and out_32bit=32'hD9CE3DCB.
- Hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid during LOOKUP and DONE. Required: out_32bit stable, in_ready=0, no second capture, IDLE one cycle after out_ready=1.
- Assert n_rst low at LOOKUP cycle 4. Required: all outputs at reset values immediately, then a fresh word completes correctly with no stale nibbles.
- Replace the S-box model with sbox_out={1'b0,sbox_sel}. Required: out_32bit=32'h01234567, which checks nibble placement and ordering.
- With SBOX_SEQ_ABORT_EN defined, assert abort at LOOKUP cycle 3. Required: IDLE next cycle, out_valid never asserted. Assert abort together with in_valid in IDLE. Required: word not accepted, busy stays 0.

Source files
------------

// File: rtl/sbox_sequencer_if.sv
// rtl/sbox_sequencer_if.sv - handshake and S-box lookup bundle for sbox_sequencer
// abort exists only when SBOX_SEQ_ABORT_EN is defined.
interface sbox_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_48bit;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_in;
  logic [3:0]  sbox_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_32bit;
  logic        busy;
`ifdef SBOX_SEQ_ABORT_EN
  logic        abort;

  modport slave (
    input  in_valid, in_48bit, sbox_out, out_ready, abort,
    output in_ready, sbox_sel, sbox_in, out_valid, out_32bit, busy
  );

  modport master (
    output in_valid, in_48bit, sbox_out, out_ready, abort,
    input  in_ready, sbox_sel, sbox_in, out_valid, out_32bit, busy
  );
`else
  modport slave (
    input  in_valid, in_48bit, sbox_out, out_ready,
    output in_ready, sbox_sel, sbox_in, out_valid, out_32bit, busy
  );

  modport master (
    output in_valid, in_48bit, sbox_out, out_ready,
    input  in_ready, sbox_sel, sbox_in, out_valid, out_32bit, busy
  );
`endif
endinterface

// File: rtl/sbox_sequencer.sv
// rtl/sbox_sequencer.sv - time-multiplexes one DES S-box port over the eight round substitutions
// Optional abort input enabled by defining SBOX_SEQ_ABORT_EN.
module sbox_sequencer (
  input logic             clk,
  input logic             n_rst,
  sbox_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  k;
  logic [2:0]  k_next;
  logic [47:0] data;
  logic [47:0] data_next;
  logic [31:0] result;
  logic [31:0] result_next;
  logic        abort_req;

`ifdef SBOX_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Chunk k sits at data[47-6k -: 6]; shifting it to the top avoids a wide mux tree.
  logic [5:0]  chunk_shift;
  logic [47:0] chunk_window;
  assign chunk_shift  = 6'd6 * {3'b000, k};
  assign chunk_window = data << chunk_shift;

  // Result nibble k lives at bit offset 4*(7-k), i.e. {~k, 2'b00}.
  logic [4:0]  slot_shift;
  logic [31:0] slot_mask;
  logic [31:0] slot_value;
  assign slot_shift = {~k, 2'b00};
  assign slot_mask  = 32'hF << slot_shift;
  assign slot_value = {28'd0, bus.sbox_out} << slot_shift;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      k      <= 3'd0;
      data   <= 48'd0;
      result <= 32'd0;
    end else begin
      state  <= state_next;
      k      <= k_next;
      data   <= data_next;
      result <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    k_next      = k;
    data_next   = data;
    result_next = result;
    case (state)
      IDLE: begin
        if (!abort_req && bus.in_valid) begin
          state_next  = LOOKUP;
          data_next   = bus.in_48bit;
          k_next      = 3'd0;
          result_next = 32'd0;
        end
      end
      LOOKUP: begin
        result_next = (result & ~slot_mask) | slot_value;
        if (k == 3'd7) begin
          state_next = DONE;
        end else begin
          k_next = k + 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort_req && (state != IDLE)) begin
      state_next  = IDLE;
      k_next      = 3'd0;
      result_next = 32'd0;
    end
  end

  // Lookup port is a function of registered state only, so the S-box settles in-cycle.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DONE);
    bus.out_32bit = result;
    bus.sbox_sel  = 3'd0;
    bus.sbox_in   = 6'd0;
    if (state == LOOKUP) begin
      bus.sbox_sel = k;
      bus.sbox_in  = chunk_window[47:42];
    end
  end

endmodule

// File: tb/tb_sbox_sequencer.sv
// tb/tb_sbox_sequencer.sv - randomized self-checking bench for sbox_sequencer
// Abort scenarios run only when SBOX_SEQ_ABORT_EN is defined.
module tb_sbox_sequencer;

  logic clk;
  logic n_rst;
  int   vectors;
  int   miscompares;
  bit   ident_mode;
  logic [255:0] sbt [8];

  sbox_sequencer_if bus();

  sbox_sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External S-box bank model: row = {b5,b0}, column = b4..b1, nibble 0 is the MSB of the row string.
  logic [255:0] m_row;
  int           m_idx;
  always_comb begin
    m_row = sbt[bus.sbox_sel];
    m_idx = int'({bus.sbox_in[5], bus.sbox_in[0], bus.sbox_in[4:1]});
    if (ident_mode) bus.sbox_out = {1'b0, bus.sbox_sel};
    else            bus.sbox_out = m_row[255 - 4*m_idx -: 4];
  end

  function automatic logic [3:0] ref_sbox(input int sel, input logic [5:0] x);
    logic [255:0] row;
    int idx;
    logic [31:0] s;
    row = sbt[sel];
    idx = int'({x[5], x[0], x[4:1]});
    s = 32'(sel);
    if (ident_mode) return {1'b0, s[2:0]};
    return row[255 - 4*idx -: 4];
  endfunction

  function automatic logic [31:0] ref_word(input logic [47:0] w);
    logic [31:0] r;
    logic [47:0] t;
    r = 32'd0;
    t = w;
    for (int j = 0; j < 8; j++) begin
      r = {r[27:0], ref_sbox(j, t[47:42])};
      t = t << 6;
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  // Drives one word from IDLE; cut >= 0 interrupts in LOOKUP cycle cut+1 by reset or abort.
  task automatic run_word(input logic [47:0] w, input int hold, input bit pulse,
                          input int cut, input bit use_abort, output logic [31:0] got);
    logic [31:0] exp;
    logic [5:0]  chunk;
    exp = ref_word(w);
    got = 32'hx;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before_word: in_ready=%b busy=%b, want 1/0", bus.in_ready, bus.busy);
    end
    bus.in_valid  = 1'b1;
    bus.in_48bit  = w;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_48bit = rand48();
    for (int j = 0; j < 8; j++) begin
      chunk = w[47 - 6*j -: 6];
      vectors++;
      if (bus.sbox_sel !== 3'(j) || bus.sbox_in !== chunk || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL lookup_cycle%0d: sel=%0d in=%h rdy=%b ov=%b busy=%b, want sel=%0d in=%h 0/0/1",
                 j + 1, bus.sbox_sel, bus.sbox_in, bus.in_ready, bus.out_valid, bus.busy, j, chunk);
      end
      if (pulse) bus.in_valid = 1'($urandom_range(0, 1));
      if (j == cut) begin
        if (use_abort) begin
`ifdef SBOX_SEQ_ABORT_EN
          bus.abort = 1'b1;
          @(negedge clk);
          bus.abort    = 1'b0;
          bus.in_valid = 1'b0;
          for (int c = 0; c < 12; c++) begin
            vectors++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
                bus.sbox_sel !== 3'd0 || bus.sbox_in !== 6'd0) begin
              miscompares++;
              $display("FAIL after_abort_c%0d: busy=%b ov=%b rdy=%b sel=%0d in=%h, want idle",
                       c, bus.busy, bus.out_valid, bus.in_ready, bus.sbox_sel, bus.sbox_in);
            end
            @(negedge clk);
          end
`endif
        end else begin
          n_rst = 1'b0;
          #1;
          vectors++;
          if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
              bus.sbox_sel !== 3'd0 || bus.sbox_in !== 6'd0 || bus.out_32bit !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset_mid: rdy=%b ov=%b busy=%b sel=%0d in=%h out=%h, want 1/0/0/0/00/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sbox_sel, bus.sbox_in, bus.out_32bit);
          end
          bus.in_valid = 1'b0;
          @(negedge clk);
          n_rst = 1'b1;
          @(negedge clk);
        end
        return;
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_32bit !== exp || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_result: ov=%b out=%h rdy=%b, want 1 %h 0", bus.out_valid, bus.out_32bit, bus.in_ready, exp);
    end
    got = bus.out_32bit;
    for (int h = 0; h < hold; h++) begin
      if (pulse) bus.in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_32bit !== exp || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL done_hold%0d: ov=%b out=%h rdy=%b, want 1 %h 0", h, bus.out_valid, bus.out_32bit, bus.in_ready, exp);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL return_idle: ov=%b rdy=%b busy=%b, want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sbox_sel !== 3'd0 || bus.sbox_in !== 6'd0 || bus.out_32bit !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b ov=%b busy=%b sel=%0d in=%h out=%h, want 1/0/0/0/00/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.sbox_sel, bus.sbox_in, bus.out_32bit);
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [31:0] got;
    run_word(48'h000000000000, 0, 1'b0, -1, 1'b0, got);
    vectors++;
    if (got !== 32'hEFA72C4D) begin
      miscompares++;
      $display("FAIL zero_word: got %h, want efa72c4d", got);
    end
    run_word(48'hFFFFFFFFFFFF, 0, 1'b0, -1, 1'b0, got);
    vectors++;
    if (got !== 32'hD9CE3DCB) begin
      miscompares++;
      $display("FAIL ones_word: got %h, want d9ce3dcb", got);
    end
  endtask

  task automatic test_hold_and_ignore();
    logic [31:0] got;
    run_word(rand48(), 5, 1'b1, -1, 1'b0, got);
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL no_second_capture: busy=%b rdy=%b, want 0/1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_lookup();
    logic [31:0] got;
    run_word(48'hFFFFFFFFFFFF, 0, 1'b0, 3, 1'b0, got);
    run_word(48'h000000000000, 0, 1'b0, -1, 1'b0, got);
    vectors++;
    if (got !== 32'hEFA72C4D) begin
      miscompares++;
      $display("FAIL fresh_after_reset: got %h, want efa72c4d", got);
    end
  endtask

  task automatic test_placement();
    logic [31:0] got;
    ident_mode = 1'b1;
    run_word(rand48(), 1, 1'b0, -1, 1'b0, got);
    vectors++;
    if (got !== 32'h01234567) begin
      miscompares++;
      $display("FAIL nibble_placement: got %h, want 01234567", got);
    end
    ident_mode = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 8; i++) begin
      run_word(rand48(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 1'b0, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    for (int i = 0; i < 4; i++) begin
      run_word(rand48(), 0, 1'b0, -1, 1'b0, got);
    end
  endtask

`ifdef SBOX_SEQ_ABORT_EN
  task automatic test_abort();
    logic [31:0] got;
    run_word(rand48(), 0, 1'b0, 2, 1'b1, got);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_48bit = rand48();
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.sbox_sel !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_priority_idle: busy=%b rdy=%b sel=%0d, want 0/1/0", bus.busy, bus.in_ready, bus.sbox_sel);
    end
    run_word(48'hFFFFFFFFFFFF, 0, 1'b0, -1, 1'b0, got);
    vectors++;
    if (got !== 32'hD9CE3DCB) begin
      miscompares++;
      $display("FAIL word_after_abort: got %h, want d9ce3dcb", got);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    ident_mode  = 1'b0;
    sbt[0] = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    sbt[1] = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    sbt[2] = 256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    sbt[3] = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    sbt[4] = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    sbt[5] = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    sbt[6] = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    sbt[7] = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_48bit  = 48'd0;
    bus.out_ready = 1'b1;
`ifdef SBOX_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_known_vectors();
    test_hold_and_ignore();
    test_reset_mid_lookup();
    test_placement();
    test_random();
    test_back_to_back();
`ifdef SBOX_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
